// File: rtl/char_move_ctrl.sv
// Tile-stepped player movement controller: turns held direction keys into whole-tile
// walk/run steps with collision and map-edge bumping, and drives the sprite frame.
module char_move_ctrl #(
  parameter int unsigned STEP_PX  = 16,
  parameter int unsigned ANIM_DIV = 10,
  parameter int unsigned MAP_W    = 32,
  parameter int unsigned MAP_H    = 32,
  parameter int unsigned COORD_W  = 6,
  parameter int unsigned START_X  = 0,
  parameter int unsigned START_Y  = 0
) (
  input  logic                        Clk,
  input  logic                        Reset,
  input  logic                        frame_tick,
  input  logic                        enable,
  input  logic                        key_valid,
  input  logic [1:0]                  key_dir,
  input  logic                        key_run,
  input  logic                        blocked,
  output logic [COORD_W-1:0]          target_x,
  output logic [COORD_W-1:0]          target_y,
  output logic [COORD_W-1:0]          tile_x,
  output logic [COORD_W-1:0]          tile_y,
  output logic [$clog2(STEP_PX)-1:0]  pixel_offset,
  output logic [1:0]                  direction,
  output logic                        is_moving,
  output logic                        is_running,
  output logic                        is_bumping,
  output logic [1:0]                  move_frame
);

  localparam int unsigned OFF_W    = $clog2(STEP_PX);
  localparam int unsigned ANIM_MAX = 4 * ANIM_DIV;
  localparam int unsigned ANIM_W   = $clog2(ANIM_MAX);

  localparam logic [1:0] DIR_DOWN  = 2'd0;
  localparam logic [1:0] DIR_UP    = 2'd1;
  localparam logic [1:0] DIR_LEFT  = 2'd2;
  localparam logic [1:0] DIR_RIGHT = 2'd3;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WALK = 2'd1,
    S_BUMP = 2'd2
  } state_t;

  state_t              r_state;
  state_t              w_state_nxt;
  logic [COORD_W-1:0]  r_tile_x;
  logic [COORD_W-1:0]  r_tile_y;
  logic [1:0]          r_dir;
  logic [OFF_W-1:0]    r_offset;
  logic                r_run;
  logic [ANIM_W-1:0]   r_anim_cnt;
  logic [OFF_W-1:0]    r_bump_cnt;

  logic                w_at_edge;
  logic                w_key_match;
  logic                w_idle_go;
  logic                w_start_walk;
  logic                w_start_bump;
  logic                w_turn;
  logic [OFF_W:0]      w_speed;
  logic [OFF_W:0]      w_off_sum;
  logic                w_step_done;
  logic                w_bump_done;
  logic [ANIM_W:0]     w_anim_inc;
  logic [ANIM_W:0]     w_anim_sum;
  logic [ANIM_W-1:0]   w_anim_nxt;
  logic [COORD_W-1:0]  w_tgt_x;
  logic [COORD_W-1:0]  w_tgt_y;

  // Map-edge detection for the current facing; an edge behaves like a blocked tile
  always_comb begin
    w_at_edge = 1'b0;
    case (r_dir)
      DIR_DOWN:  w_at_edge = (r_tile_y == COORD_W'(MAP_H - 1));
      DIR_UP:    w_at_edge = (r_tile_y == '0);
      DIR_LEFT:  w_at_edge = (r_tile_x == '0);
      DIR_RIGHT: w_at_edge = (r_tile_x == COORD_W'(MAP_W - 1));
      default:   w_at_edge = 1'b0;
    endcase
  end

  // Neighbour tile in the facing direction, saturated at the map edge
  always_comb begin
    w_tgt_x = r_tile_x;
    w_tgt_y = r_tile_y;
    if (!w_at_edge) begin
      case (r_dir)
        DIR_DOWN:  w_tgt_y = r_tile_y + COORD_W'(1);
        DIR_UP:    w_tgt_y = r_tile_y - COORD_W'(1);
        DIR_LEFT:  w_tgt_x = r_tile_x - COORD_W'(1);
        DIR_RIGHT: w_tgt_x = r_tile_x + COORD_W'(1);
        default:   w_tgt_x = r_tile_x;
      endcase
    end
  end

  assign w_key_match  = key_valid && (key_dir == r_dir);
  assign w_idle_go    = (r_state == S_IDLE) && enable;
  assign w_start_walk = w_idle_go && w_key_match && !blocked && !w_at_edge;
  assign w_start_bump = w_idle_go && w_key_match && (blocked || w_at_edge);
  assign w_turn       = w_idle_go && key_valid && (key_dir != r_dir);

  assign w_speed     = r_run ? (OFF_W+1)'(2) : (OFF_W+1)'(1);
  assign w_off_sum   = {1'b0, r_offset} + w_speed;
  assign w_step_done = (w_off_sum == (OFF_W+1)'(STEP_PX));
  assign w_bump_done = (r_bump_cnt == OFF_W'(STEP_PX - 1));

  // Animation counter advance with wrap modulo 4*ANIM_DIV
  assign w_anim_inc = r_run ? (ANIM_W+1)'(2) : (ANIM_W+1)'(1);
  assign w_anim_sum = {1'b0, r_anim_cnt} + w_anim_inc;
  always_comb begin
    w_anim_nxt = ANIM_W'(w_anim_sum);
    if (w_anim_sum >= (ANIM_W+1)'(ANIM_MAX)) begin
      w_anim_nxt = ANIM_W'(w_anim_sum - (ANIM_W+1)'(ANIM_MAX));
    end
  end

  // State register
  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic; only frame ticks advance the FSM
  always_comb begin
    w_state_nxt = r_state;
    if (frame_tick) begin
      case (r_state)
        S_IDLE: begin
          if (w_start_walk) begin
            w_state_nxt = S_WALK;
          end else if (w_start_bump) begin
            w_state_nxt = S_BUMP;
          end
        end
        S_WALK:  if (w_step_done) w_state_nxt = S_IDLE;
        S_BUMP:  if (w_bump_done) w_state_nxt = S_IDLE;
        default: w_state_nxt = S_IDLE;
      endcase
    end
  end

  // Position, facing, step offset and counters
  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_tile_x   <= COORD_W'(START_X);
      r_tile_y   <= COORD_W'(START_Y);
      r_dir      <= DIR_UP;
      r_offset   <= '0;
      r_run      <= 1'b0;
      r_anim_cnt <= '0;
      r_bump_cnt <= '0;
    end else if (frame_tick) begin
      case (r_state)
        S_IDLE: begin
          if (w_turn) begin
            r_dir <= key_dir;
          end
          if (w_start_walk) begin
            r_run    <= key_run;
            r_offset <= key_run ? OFF_W'(2) : OFF_W'(1);
          end else if (w_start_bump) begin
            r_bump_cnt <= OFF_W'(1);
          end else begin
            r_anim_cnt <= '0;
          end
        end
        S_WALK: begin
          r_anim_cnt <= w_anim_nxt;
          if (w_step_done) begin
            r_offset <= '0;
            r_tile_x <= w_tgt_x;
            r_tile_y <= w_tgt_y;
          end else begin
            r_offset <= OFF_W'(w_off_sum);
          end
        end
        S_BUMP: begin
          r_anim_cnt <= w_anim_nxt;
          r_bump_cnt <= w_bump_done ? '0 : r_bump_cnt + OFF_W'(1);
        end
        default: begin
          r_offset <= '0;
        end
      endcase
    end
  end

  // Output decode from registered state
  always_comb begin
    is_moving  = 1'b0;
    is_running = 1'b0;
    is_bumping = 1'b0;
    move_frame = 2'd0;
    case (r_state)
      S_WALK: begin
        is_moving  = 1'b1;
        is_running = r_run;
      end
      S_BUMP:  is_bumping = 1'b1;
      default: is_moving  = 1'b0;
    endcase
    if (r_state != S_IDLE) begin
      if (r_anim_cnt < ANIM_W'(ANIM_DIV)) begin
        move_frame = 2'd0;
      end else if (r_anim_cnt < ANIM_W'(2 * ANIM_DIV)) begin
        move_frame = 2'd1;
      end else if (r_anim_cnt < ANIM_W'(3 * ANIM_DIV)) begin
        move_frame = 2'd2;
      end else begin
        move_frame = 2'd1;
      end
    end
  end

  assign target_x     = w_tgt_x;
  assign target_y     = w_tgt_y;
  assign tile_x       = r_tile_x;
  assign tile_y       = r_tile_y;
  assign pixel_offset = r_offset;
  assign direction    = r_dir;

endmodule
